// File: rtl/l1_mem_arbiter_if.sv
// Shared payload types and the bus interface between the L1 caches, the arbiter and main memory.
// The arbiter connects through the slave modport; the caches/memory side uses master.
package l1_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

endpackage : l1_mem_arbiter_pkg

interface l1_mem_arbiter_if #(
  parameter int unsigned CNT_W = 32
);
  import l1_mem_arbiter_pkg::*;

  mem_req_type       ic_req_i;
  mem_req_type       dc_req_i;
  mem_data_type      mem_data_i;
  mem_data_type      ic_data_o;
  mem_data_type      dc_data_o;
  mem_req_type       mem_req_o;
  logic              busy_o;
  logic [CNT_W-1:0]  no_ic_grant_o;
  logic [CNT_W-1:0]  no_dc_grant_o;
  logic [CNT_W-1:0]  no_conflict_o;

  modport slave (
    input  ic_req_i,
    input  dc_req_i,
    input  mem_data_i,
    output ic_data_o,
    output dc_data_o,
    output mem_req_o,
    output busy_o,
    output no_ic_grant_o,
    output no_dc_grant_o,
    output no_conflict_o
  );

  modport master (
    output ic_req_i,
    output dc_req_i,
    output mem_data_i,
    input  ic_data_o,
    input  dc_data_o,
    input  mem_req_o,
    input  busy_o,
    input  no_ic_grant_o,
    input  no_dc_grant_o,
    input  no_conflict_o
  );

endinterface : l1_mem_arbiter_if

// File: rtl/l1_mem_arbiter.sv
// Arbitrates the single main-memory port between the L1 I-cache and D-cache, holding each grant
// until memory ready. Define L1_ARB_ROUND_ROBIN_EN for round-robin conflicts; default is D-cache priority.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  l1_mem_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic             ic_win_c;
  logic             dc_win_c;
  logic             conflict_c;
  logic [CNT_W-1:0] ic_cnt_q;
  logic [CNT_W-1:0] dc_cnt_q;
  logic [CNT_W-1:0] cf_cnt_q;

`ifdef L1_ARB_ROUND_ROBIN_EN
  localparam logic LAST_IC = 1'b0;
  localparam logic LAST_DC = 1'b1;

  logic last_gnt_q;

  // Remembers the most recent winner so the other port wins the next conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= LAST_IC;
    end else if (ic_win_c) begin
      last_gnt_q <= LAST_IC;
    end else if (dc_win_c) begin
      last_gnt_q <= LAST_DC;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, arbitration decision and combinational bus routing.
  always_comb begin
    state_d        = state_q;
    ic_win_c       = 1'b0;
    dc_win_c       = 1'b0;
    conflict_c     = 1'b0;
    bus.mem_req_o  = '0;
    bus.ic_data_o  = '0;
    bus.dc_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (bus.ic_req_i.valid && bus.dc_req_i.valid) begin
          conflict_c = 1'b1;
`ifdef L1_ARB_ROUND_ROBIN_EN
          if (last_gnt_q == LAST_IC) begin
            dc_win_c = 1'b1;
          end else begin
            ic_win_c = 1'b1;
          end
`else
          dc_win_c = 1'b1;
`endif
        end else if (bus.ic_req_i.valid) begin
          ic_win_c = 1'b1;
        end else if (bus.dc_req_i.valid) begin
          dc_win_c = 1'b1;
        end

        if (ic_win_c) begin
          state_d = GNT_IC;
        end else if (dc_win_c) begin
          state_d = GNT_DC;
        end
      end

      GNT_IC: begin
        bus.mem_req_o = bus.ic_req_i;
        bus.ic_data_o = bus.mem_data_i;
        if (bus.mem_data_i.ready) begin
          state_d = IDLE;
        end
      end

      GNT_DC: begin
        bus.mem_req_o = bus.dc_req_i;
        bus.dc_data_o = bus.mem_data_i;
        if (bus.mem_data_i.ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      if (ic_win_c) begin
        ic_cnt_q <= ic_cnt_q + CNT_W'(1);
      end
      if (dc_win_c) begin
        dc_cnt_q <= dc_cnt_q + CNT_W'(1);
      end
      if (conflict_c) begin
        cf_cnt_q <= cf_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.no_ic_grant_o = ic_cnt_q;
  assign bus.no_dc_grant_o = dc_cnt_q;
  assign bus.no_conflict_o = cf_cnt_q;

endmodule : l1_mem_arbiter

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter; expectations follow L1_ARB_ROUND_ROBIN_EN when defined.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   exp_ic;
  int   exp_dc;
  int   exp_cf;
  logic [127:0] line_a5;

  l1_mem_arbiter_if #(.CNT_W(CNT_W)) bus ();

  l1_mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_ic_cnt"}, 192'(bus.no_ic_grant_o), 192'(exp_ic));
    check({tag, "_dc_cnt"}, 192'(bus.no_dc_grant_o), 192'(exp_dc));
    check({tag, "_cf_cnt"}, 192'(bus.no_conflict_o), 192'(exp_cf));
  endtask

  task automatic set_ic(input logic v, input logic rw, input logic [31:0] a, input logic [127:0] d);
    bus.ic_req_i.valid = v;
    bus.ic_req_i.rw    = rw;
    bus.ic_req_i.addr  = a;
    bus.ic_req_i.data  = d;
  endtask

  task automatic set_dc(input logic v, input logic rw, input logic [31:0] a, input logic [127:0] d);
    bus.dc_req_i.valid = v;
    bus.dc_req_i.rw    = rw;
    bus.dc_req_i.addr  = a;
    bus.dc_req_i.data  = d;
  endtask

  task automatic set_mem(input logic rdy, input logic [127:0] d);
    bus.mem_data_i.ready = rdy;
    bus.mem_data_i.data  = d;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_ic  = 0;
    exp_dc  = 0;
    exp_cf  = 0;
    line_a5 = {16{8'hA5}};
    rst_n   = 1'b0;
    set_ic(1'b0, 1'b0, 32'h0, 128'h0);
    set_dc(1'b0, 1'b0, 32'h0, 128'h0);
    set_mem(1'b0, 128'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset release: nothing granted, counters clear.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_valid", 192'(bus.mem_req_o.valid), 192'(0));
      check("rst_busy", 192'(bus.busy_o), 192'(0));
      if (i == 9) check_counters("rst");
    end

    // Single IC read with a 3-cycle memory latency.
    set_ic(1'b1, 1'b0, 32'h0000_1000, 128'h0);
    settle();
    check("ic_pre_busy", 192'(bus.busy_o), 192'(0));
    tick();
    exp_ic++;
    check("ic_gnt_valid", 192'(bus.mem_req_o.valid), 192'(1));
    check("ic_gnt_addr", 192'(bus.mem_req_o.addr), 192'(32'h0000_1000));
    check("ic_gnt_busy", 192'(bus.busy_o), 192'(1));
    check_counters("ic_gnt");
    tick();
    check("ic_wait_rdy", 192'(bus.ic_data_o.ready), 192'(0));
    tick();
    set_mem(1'b1, line_a5);
    settle();
    check("ic_rsp_data", 192'(bus.ic_data_o.data), 192'(line_a5));
    check("ic_rsp_rdy", 192'(bus.ic_data_o.ready), 192'(1));
    check("ic_rsp_dc_rdy", 192'(bus.dc_data_o.ready), 192'(0));
    check("ic_rsp_dc_data", 192'(bus.dc_data_o.data), 192'(0));
    set_ic(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    check("ic_done_busy", 192'(bus.busy_o), 192'(0));
    check("ic_done_valid", 192'(bus.mem_req_o.valid), 192'(0));
    check("idle_rdy_ignored", 192'(bus.ic_data_o.ready), 192'(0));
    set_mem(1'b0, 128'h0);

    // Four back-to-back conflicts.
    set_ic(1'b1, 1'b0, 32'h0000_2000, 128'h0);
    set_dc(1'b1, 1'b0, 32'h0000_3000, 128'h0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_addr;
`ifdef L1_ARB_ROUND_ROBIN_EN
      exp_addr = (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_2000;
`else
      exp_addr = 32'h0000_3000;
`endif
      tick();
      exp_cf++;
      if (exp_addr == 32'h0000_3000) exp_dc++;
      else exp_ic++;
      check($sformatf("cf%0d_addr", k), 192'(bus.mem_req_o.addr), 192'(exp_addr));
      check($sformatf("cf%0d_busy", k), 192'(bus.busy_o), 192'(1));
      set_mem(1'b1, 128'h1234);
      settle();
      check($sformatf("cf%0d_ic_rdy", k), 192'(bus.ic_data_o.ready),
            192'(exp_addr == 32'h0000_2000));
      check($sformatf("cf%0d_dc_rdy", k), 192'(bus.dc_data_o.ready),
            192'(exp_addr == 32'h0000_3000));
      tick();
      set_mem(1'b0, 128'h0);
      if (k == 3) begin
        set_ic(1'b0, 1'b0, 32'h0, 128'h0);
        set_dc(1'b0, 1'b0, 32'h0, 128'h0);
      end
      settle();
      check($sformatf("cf%0d_turn_busy", k), 192'(bus.busy_o), 192'(0));
      check($sformatf("cf%0d_turn_valid", k), 192'(bus.mem_req_o.valid), 192'(0));
    end
    check_counters("cf");

    // DC write-back in flight; IC arrives and must wait for the turnaround.
    set_dc(1'b1, 1'b1, 32'h0000_5000, 128'hDEAD_BEEF);
    tick();
    exp_dc++;
    check("wb_dc_addr", 192'(bus.mem_req_o.addr), 192'(32'h0000_5000));
    check("wb_dc_rw", 192'(bus.mem_req_o.rw), 192'(1));
    check("wb_dc_wdata", 192'(bus.mem_req_o.data), 192'(128'hDEAD_BEEF));
    set_ic(1'b1, 1'b0, 32'h0000_4000, 128'h0);
    tick();
    check("wb_still_dc", 192'(bus.mem_req_o.addr), 192'(32'h0000_5000));
    check("wb_ic_no_rdy", 192'(bus.ic_data_o.ready), 192'(0));
    set_mem(1'b1, 128'h0);
    settle();
    check("wb_ic_no_early", 192'(bus.ic_data_o.ready), 192'(0));
    check("wb_dc_rdy", 192'(bus.dc_data_o.ready), 192'(1));
    set_dc(1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    set_mem(1'b0, 128'h0);
    settle();
    check("wb_m1_idle", 192'(bus.busy_o), 192'(0));
    check("wb_m1_valid", 192'(bus.mem_req_o.valid), 192'(0));
    tick();
    exp_ic++;
    check("wb_m2_ic_addr", 192'(bus.mem_req_o.addr), 192'(32'h0000_4000));
    check_counters("wb");

    // Granted IC drops valid; grant must hold until ready, DC kept waiting.
    set_ic(1'b0, 1'b0, 32'h0000_4000, 128'h0);
    set_dc(1'b1, 1'b0, 32'h0000_6000, 128'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("drop%0d_busy", j), 192'(bus.busy_o), 192'(1));
      check($sformatf("drop%0d_addr", j), 192'(bus.mem_req_o.addr), 192'(32'h0000_4000));
    end
    set_mem(1'b1, 128'h77);
    settle();
    check("drop_ic_rdy", 192'(bus.ic_data_o.ready), 192'(1));
    check("drop_dc_rdy", 192'(bus.dc_data_o.ready), 192'(0));
    tick();
    set_mem(1'b0, 128'h0);
    settle();
    check("drop_idle", 192'(bus.busy_o), 192'(0));
    tick();
    exp_dc++;
    check("drop_dc_gnt", 192'(bus.mem_req_o.addr), 192'(32'h0000_6000));
    check_counters("drop");

    // Asynchronous reset in the middle of the DC grant.
    set_mem(1'b1, 128'hFFFF);
    settle();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 192'(bus.busy_o), 192'(0));
    check("arst_mem_req", 192'(bus.mem_req_o), 192'(0));
    check("arst_dc_data", 192'(bus.dc_data_o), 192'(0));
    check("arst_ic_data", 192'(bus.ic_data_o), 192'(0));
    exp_ic = 0;
    exp_dc = 0;
    exp_cf = 0;
    check_counters("arst");
    set_mem(1'b0, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_dc++;
    check("post_rst_valid", 192'(bus.mem_req_o.valid), 192'(1));
    check("post_rst_addr", 192'(bus.mem_req_o.addr), 192'(32'h0000_6000));
    check_counters("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_l1_mem_arbiter
